// File: rtl/fuzzy_defuzz_if.sv
// Grade/result handshake bundle for the defuzzifier.
// The master side presents grades and accepts crisp results; the slave side is the defuzzifier.
interface fuzzy_defuzz_if;
   logic       in_valid;
   logic       in_ready;
   logic [9:0] mu_min;
   logic [9:0] mu_mid;
   logic [9:0] mu_max;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic       out_err;

   modport master (
      output in_valid, mu_min, mu_mid, mu_max, out_ready,
      input  in_ready, out_valid, out_data, out_err
   );

   modport slave (
      input  in_valid, mu_min, mu_mid, mu_max, out_ready,
      output in_ready, out_valid, out_data, out_err
   );
endinterface

// File: rtl/fuzzy_defuzz.sv
// Weighted-singleton centroid defuzzifier: three membership grades in, one crisp 8-bit value out.
// The products are registered, then an 8-step restoring divider runs, MSB first.
// Build option FUZZY_DEFUZZ_ROUND_EN: adds den/2 to the numerator so the result rounds half-up
// instead of truncating. Latency and zero-denominator behaviour are the same in both builds.
//
// state  | meaning
// S_IDLE | ready for grades, in_ready high
// S_MUL  | numerator/denominator registered, zero denominator short-circuits to S_DONE
// S_DIV  | one restoring step per cycle, bit_cnt counts 7 down to 0
// S_DONE | result presented with out_valid until out_ready
module fuzzy_defuzz #(
   parameter logic [7:0] C_MIN       = 8'd0,
   parameter logic [7:0] C_MID       = 8'd128,
   parameter logic [7:0] C_MAX       = 8'd255,
   parameter logic [7:0] DEFAULT_OUT = 8'd128
) (
   input logic           clk,
   input logic           rst,
   fuzzy_defuzz_if.slave bus
);

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

   state_t      state;
   state_t      state_nxt;

   logic [9:0]  g_min;
   logic [9:0]  g_mid;
   logic [9:0]  g_max;
   logic [11:0] den_r;
   logic [19:0] rem;
   logic [7:0]  quo;
   logic [2:0]  bit_cnt;
   logic [7:0]  data_r;
   logic        err_r;

   logic [19:0] num_w;
   logic [11:0] den_w;
   logic [19:0] num_adj;
   logic [19:0] den_sh;
   logic        rem_ge;
   logic [7:0]  bit_mask;
   logic [7:0]  q_next;

   assign num_w = 20'(g_min) * 20'(C_MIN)
                + 20'(g_mid) * 20'(C_MID)
                + 20'(g_max) * 20'(C_MAX);
   assign den_w = 12'(g_min) + 12'(g_mid) + 12'(g_max);

`ifdef FUZZY_DEFUZZ_ROUND_EN
   // Half the denominator turns the floor into round-half-up; num stays <= 255*den + den/2.
   assign num_adj = num_w + {9'd0, den_w[11:1]};
`else
   assign num_adj = num_w;
`endif

   assign den_sh   = {8'd0, den_r} << bit_cnt;
   assign rem_ge   = (rem >= den_sh);
   assign bit_mask = 8'd1 << bit_cnt;
   assign q_next   = rem_ge ? (quo | bit_mask) : quo;

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // Next-state decode
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (bus.in_valid)       state_nxt = S_MUL;
         S_MUL:  state_nxt = (den_w == 12'd0) ? S_DONE : S_DIV;
         S_DIV:  if (bit_cnt == 3'd0)    state_nxt = S_DONE;
         S_DONE: if (bus.out_ready)      state_nxt = S_IDLE;
         default:                        state_nxt = S_IDLE;
      endcase
   end

   // Handshake and result outputs
   always_comb begin
      bus.in_ready  = (state == S_IDLE);
      bus.out_valid = (state == S_DONE);
      bus.out_data  = data_r;
      bus.out_err   = err_r;
   end

   // Grade capture, product registers and restoring divider
   always_ff @(posedge clk) begin
      if (rst) begin
         g_min   <= '0;
         g_mid   <= '0;
         g_max   <= '0;
         den_r   <= '0;
         rem     <= '0;
         quo     <= '0;
         bit_cnt <= '0;
         data_r  <= '0;
         err_r   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.in_valid) begin
                  g_min <= bus.mu_min;
                  g_mid <= bus.mu_mid;
                  g_max <= bus.mu_max;
               end
            end
            S_MUL: begin
               den_r   <= den_w;
               rem     <= num_adj;
               quo     <= '0;
               bit_cnt <= 3'd7;
               if (den_w == 12'd0) begin
                  data_r <= DEFAULT_OUT;
                  err_r  <= 1'b1;
               end
            end
            S_DIV: begin
               if (rem_ge) rem <= rem - den_sh;
               quo     <= q_next;
               bit_cnt <= bit_cnt - 3'd1;
               if (bit_cnt == 3'd0) begin
                  data_r <= q_next;
                  err_r  <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
